// File: rtl/reservation_station.sv
// Reservation station for ALU/jump/branch ops: buffers dispatched ops until both operands
// are resolved (snooping ALU and LSB CDBs) and issues the lowest-index ready op each cycle.
module reservation_station #(
    parameter int RS_SIZE    = 16,
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int OP_WIDTH   = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,

    input  logic                  rdy_disp_in,
    input  logic [ADDR_WIDTH-1:0] pc_disp_in,
    input  logic [OP_WIDTH-1:0]   opcode_disp_in,
    input  logic [ROB_WIDTH-1:0]  qj_disp_in,
    input  logic [ROB_WIDTH-1:0]  qk_disp_in,
    input  logic [DATA_WIDTH-1:0] vj_disp_in,
    input  logic [DATA_WIDTH-1:0] vk_disp_in,
    input  logic [DATA_WIDTH-1:0] A_disp_in,
    input  logic [ROB_WIDTH-1:0]  rob_id_disp_in,
    output logic                  rs_full_out,

    input  logic                  cdb_alu_rdy_in,
    input  logic [ROB_WIDTH-1:0]  cdb_alu_rob_in,
    input  logic [DATA_WIDTH-1:0] cdb_alu_val_in,
    input  logic                  cdb_lsb_rdy_in,
    input  logic [ROB_WIDTH-1:0]  cdb_lsb_rob_in,
    input  logic [DATA_WIDTH-1:0] cdb_lsb_val_in,

    output logic                  rdy_alu_out,
    output logic [OP_WIDTH-1:0]   opcode_alu_out,
    output logic [DATA_WIDTH-1:0] vj_alu_out,
    output logic [DATA_WIDTH-1:0] vk_alu_out,
    output logic [DATA_WIDTH-1:0] A_alu_out,
    output logic [ADDR_WIDTH-1:0] pc_alu_out,
    output logic [ROB_WIDTH-1:0]  rob_id_alu_out
);

    localparam int CNT_W = $clog2(RS_SIZE + 1);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0]    busy;
    logic [OP_WIDTH-1:0]   opcode [RS_SIZE];
    logic [ADDR_WIDTH-1:0] pc     [RS_SIZE];
    logic [ROB_WIDTH-1:0]  qj     [RS_SIZE];
    logic [ROB_WIDTH-1:0]  qk     [RS_SIZE];
    logic [DATA_WIDTH-1:0] vj     [RS_SIZE];
    logic [DATA_WIDTH-1:0] vk     [RS_SIZE];
    logic [DATA_WIDTH-1:0] a      [RS_SIZE];
    logic [ROB_WIDTH-1:0]  rob_id [RS_SIZE];
    logic [CNT_W-1:0]      count;

    logic [ROB_WIDTH-1:0]  wake_qj [RS_SIZE];
    logic [ROB_WIDTH-1:0]  wake_qk [RS_SIZE];
    logic [DATA_WIDTH-1:0] wake_vj [RS_SIZE];
    logic [DATA_WIDTH-1:0] wake_vk [RS_SIZE];
    logic [ROB_WIDTH-1:0]  disp_qj;
    logic [ROB_WIDTH-1:0]  disp_qk;
    logic [DATA_WIDTH-1:0] disp_vj;
    logic [DATA_WIDTH-1:0] disp_vk;

    logic [RS_SIZE-1:0]    ready;
    logic                  issue_found;
    logic [IDX_W-1:0]      issue_idx;
    logic [IDX_W-1:0]      free_idx;
    logic                  disp_accept;

    // Resolve one operand against both CDBs; tag 0 is already resolved and never matched.
    // The ALU bus takes priority when both buses carry the same tag.
    function automatic logic [ROB_WIDTH+DATA_WIDTH-1:0] snoop(
        input logic [ROB_WIDTH-1:0]  tag,
        input logic [DATA_WIDTH-1:0] val,
        input logic                  alu_rdy,
        input logic [ROB_WIDTH-1:0]  alu_rob,
        input logic [DATA_WIDTH-1:0] alu_val,
        input logic                  lsb_rdy,
        input logic [ROB_WIDTH-1:0]  lsb_rob,
        input logic [DATA_WIDTH-1:0] lsb_val
    );
        logic [ROB_WIDTH+DATA_WIDTH-1:0] res;
        res = {tag, val};
        if (tag != '0) begin
            if (alu_rdy && alu_rob == tag) begin
                res = {{ROB_WIDTH{1'b0}}, alu_val};
            end else if (lsb_rdy && lsb_rob == tag) begin
                res = {{ROB_WIDTH{1'b0}}, lsb_val};
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            {wake_qj[i], wake_vj[i]} = snoop(qj[i], vj[i],
                cdb_alu_rdy_in, cdb_alu_rob_in, cdb_alu_val_in,
                cdb_lsb_rdy_in, cdb_lsb_rob_in, cdb_lsb_val_in);
            {wake_qk[i], wake_vk[i]} = snoop(qk[i], vk[i],
                cdb_alu_rdy_in, cdb_alu_rob_in, cdb_alu_val_in,
                cdb_lsb_rdy_in, cdb_lsb_rob_in, cdb_lsb_val_in);
        end
        {disp_qj, disp_vj} = snoop(qj_disp_in, vj_disp_in,
            cdb_alu_rdy_in, cdb_alu_rob_in, cdb_alu_val_in,
            cdb_lsb_rdy_in, cdb_lsb_rob_in, cdb_lsb_val_in);
        {disp_qk, disp_vk} = snoop(qk_disp_in, vk_disp_in,
            cdb_alu_rdy_in, cdb_alu_rob_in, cdb_alu_val_in,
            cdb_lsb_rdy_in, cdb_lsb_rob_in, cdb_lsb_val_in);
    end

    // Readiness uses registered tags only, so a woken entry issues one edge after wake-up.
    always_comb begin
        ready       = '0;
        issue_found = 1'b0;
        issue_idx   = '0;
        free_idx    = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy[i] && (qj[i] == '0) && (qk[i] == '0);
        end
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign rs_full_out = (count == CNT_W'(RS_SIZE));
    assign disp_accept = rdy_disp_in && !rs_full_out;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy           <= '0;
            count          <= '0;
            rdy_alu_out    <= 1'b0;
            opcode_alu_out <= '0;
            vj_alu_out     <= '0;
            vk_alu_out     <= '0;
            A_alu_out      <= '0;
            pc_alu_out     <= '0;
            rob_id_alu_out <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                opcode[i] <= '0;
                pc[i]     <= '0;
                qj[i]     <= '0;
                qk[i]     <= '0;
                vj[i]     <= '0;
                vk[i]     <= '0;
                a[i]      <= '0;
                rob_id[i] <= '0;
            end
        end else if (!rdy_in) begin
            rdy_alu_out <= 1'b0;
        end else if (clear_in) begin
            busy        <= '0;
            count       <= '0;
            rdy_alu_out <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    qj[i] <= wake_qj[i];
                    qk[i] <= wake_qk[i];
                    vj[i] <= wake_vj[i];
                    vk[i] <= wake_vk[i];
                end
            end

            if (issue_found) begin
                busy[issue_idx] <= 1'b0;
                rdy_alu_out     <= 1'b1;
                opcode_alu_out  <= opcode[issue_idx];
                vj_alu_out      <= vj[issue_idx];
                vk_alu_out      <= vk[issue_idx];
                A_alu_out       <= a[issue_idx];
                pc_alu_out      <= pc[issue_idx];
                rob_id_alu_out  <= rob_id[issue_idx];
            end else begin
                rdy_alu_out <= 1'b0;
            end

            // free_idx comes from registered busy, so it never aliases the slot issuing now.
            if (disp_accept) begin
                busy[free_idx]   <= 1'b1;
                opcode[free_idx] <= opcode_disp_in;
                pc[free_idx]     <= pc_disp_in;
                qj[free_idx]     <= disp_qj;
                qk[free_idx]     <= disp_qk;
                vj[free_idx]     <= disp_vj;
                vk[free_idx]     <= disp_vk;
                a[free_idx]      <= A_disp_in;
                rob_id[free_idx] <= rob_id_disp_in;
            end

            count <= count + CNT_W'(disp_accept) - CNT_W'(issue_found);
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed dispatch/CDB stimulus, expected issues queued
// into a scoreboard that a negedge monitor pops whenever rdy_alu_out is seen.
module tb_reservation_station;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        rdy_disp_in;
    logic [31:0] pc_disp_in;
    logic [5:0]  opcode_disp_in;
    logic [3:0]  qj_disp_in;
    logic [3:0]  qk_disp_in;
    logic [31:0] vj_disp_in;
    logic [31:0] vk_disp_in;
    logic [31:0] A_disp_in;
    logic [3:0]  rob_id_disp_in;
    logic        rs_full_out;
    logic        cdb_alu_rdy_in;
    logic [3:0]  cdb_alu_rob_in;
    logic [31:0] cdb_alu_val_in;
    logic        cdb_lsb_rdy_in;
    logic [3:0]  cdb_lsb_rob_in;
    logic [31:0] cdb_lsb_val_in;
    logic        rdy_alu_out;
    logic [5:0]  opcode_alu_out;
    logic [31:0] vj_alu_out;
    logic [31:0] vk_alu_out;
    logic [31:0] A_alu_out;
    logic [31:0] pc_alu_out;
    logic [3:0]  rob_id_alu_out;

    reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .rdy_disp_in(rdy_disp_in), .pc_disp_in(pc_disp_in), .opcode_disp_in(opcode_disp_in),
        .qj_disp_in(qj_disp_in), .qk_disp_in(qk_disp_in), .vj_disp_in(vj_disp_in),
        .vk_disp_in(vk_disp_in), .A_disp_in(A_disp_in), .rob_id_disp_in(rob_id_disp_in),
        .rs_full_out(rs_full_out),
        .cdb_alu_rdy_in(cdb_alu_rdy_in), .cdb_alu_rob_in(cdb_alu_rob_in),
        .cdb_alu_val_in(cdb_alu_val_in),
        .cdb_lsb_rdy_in(cdb_lsb_rdy_in), .cdb_lsb_rob_in(cdb_lsb_rob_in),
        .cdb_lsb_val_in(cdb_lsb_val_in),
        .rdy_alu_out(rdy_alu_out), .opcode_alu_out(opcode_alu_out), .vj_alu_out(vj_alu_out),
        .vk_alu_out(vk_alu_out), .A_alu_out(A_alu_out), .pc_alu_out(pc_alu_out),
        .rob_id_alu_out(rob_id_alu_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] a;
        logic [31:0] pc;
        logic [3:0]  rob;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Scoreboard monitor
    initial begin
        exp_t got;
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (!rst_in && rdy_alu_out) begin
                got = '{op: opcode_alu_out, vj: vj_alu_out, vk: vk_alu_out,
                        a: A_alu_out, pc: pc_alu_out, rob: rob_id_alu_out};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL issue_unexpected got rob=%0d pc=%h vj=%h", got.rob, got.pc, got.vj);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL issue_data got op=%h vj=%h vk=%h a=%h pc=%h rob=%0d exp op=%h vj=%h vk=%h a=%h pc=%h rob=%0d",
                                 got.op, got.vj, got.vk, got.a, got.pc, got.rob,
                                 e.op, e.vj, e.vk, e.a, e.pc, e.rob);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [31:0] a, input logic [31:0] pc, input logic [3:0] rob);
        exp_q.push_back('{op: op, vj: vj, vk: vk, a: a, pc: pc, rob: rob});
    endtask

    task automatic set_disp(input logic [5:0] op, input logic [31:0] pc,
                            input logic [3:0] qj, input logic [3:0] qk,
                            input logic [31:0] vj, input logic [31:0] vk,
                            input logic [31:0] a, input logic [3:0] rob);
        rdy_disp_in    = 1'b1;
        opcode_disp_in = op;
        pc_disp_in     = pc;
        qj_disp_in     = qj;
        qk_disp_in     = qk;
        vj_disp_in     = vj;
        vk_disp_in     = vk;
        A_disp_in      = a;
        rob_id_disp_in = rob;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] pc,
                        input logic [3:0] qj, input logic [3:0] qk,
                        input logic [31:0] vj, input logic [31:0] vk,
                        input logic [31:0] a, input logic [3:0] rob);
        set_disp(op, pc, qj, qk, vj, vk, a, rob);
        tick();
        rdy_disp_in = 1'b0;
    endtask

    task automatic cdb(input logic alu_v, input logic [3:0] alu_rob, input logic [31:0] alu_val,
                       input logic lsb_v, input logic [3:0] lsb_rob, input logic [31:0] lsb_val);
        cdb_alu_rdy_in = alu_v;
        cdb_alu_rob_in = alu_rob;
        cdb_alu_val_in = alu_val;
        cdb_lsb_rdy_in = lsb_v;
        cdb_lsb_rob_in = lsb_rob;
        cdb_lsb_val_in = lsb_val;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
        rdy_disp_in = 1'b0; pc_disp_in = '0; opcode_disp_in = '0; qj_disp_in = '0;
        qk_disp_in = '0; vj_disp_in = '0; vk_disp_in = '0; A_disp_in = '0; rob_id_disp_in = '0;
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        tick(); tick();
        chk("reset_rdy_alu", {31'd0, rdy_alu_out}, 32'd0);
        chk("reset_full", {31'd0, rs_full_out}, 32'd0);
        chk("reset_rob_out", {28'd0, rob_id_alu_out}, 32'd0);
        rst_in = 1'b0;
        tick();

        // Basic ready op: written at edge N, issued at N+1
        push(6'h01, 32'd7, 32'd5, 32'd0, 32'h1000, 4'd3);
        disp(6'h01, 32'h1000, 4'd0, 4'd0, 32'd7, 32'd5, 32'd0, 4'd3);
        tick(); tick();

        // Same-cycle forwarding from ALU CDB into the dispatched op
        push(6'h02, 32'h55, 32'd1, 32'h10, 32'h1004, 4'd5);
        cdb(1'b1, 4'd4, 32'h55, 1'b0, 4'd0, 32'd0);
        disp(6'h02, 32'h1004, 4'd4, 4'd0, 32'hDEAD, 32'd1, 32'h10, 4'd5);
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        tick(); tick();

        // Both buses wake distinct operands on the same edge
        push(6'h03, 32'd1, 32'd2, 32'h20, 32'h1008, 4'd7);
        disp(6'h03, 32'h1008, 4'd5, 4'd6, 32'd0, 32'd0, 32'h20, 4'd7);
        tick();
        chk("waiting_no_issue", {31'd0, rdy_alu_out}, 32'd0);
        cdb(1'b1, 4'd5, 32'd1, 1'b1, 4'd6, 32'd2);
        tick();
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        chk("wake_edge_no_issue", {31'd0, rdy_alu_out}, 32'd0);
        tick();
        chk("woken_issue", {31'd0, rdy_alu_out}, 32'd1);
        tick();

        // Equal tags on both buses: ALU value wins
        push(6'h04, 32'hA, 32'hA, 32'h30, 32'h100C, 4'd8);
        disp(6'h04, 32'h100C, 4'd7, 4'd7, 32'd0, 32'd0, 32'h30, 4'd8);
        cdb(1'b1, 4'd7, 32'hA, 1'b1, 4'd7, 32'hB);
        tick();
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        tick(); tick();

        // Reset mid-run with 5 waiting entries and an op issuing
        for (int i = 0; i < 5; i++) begin
            disp(6'h10, 32'h2000 + 32'(i), 4'd9, 4'd0, 32'd0, 32'd0, 32'd0, 4'(i + 1));
        end
        disp(6'h11, 32'h2100, 4'd0, 4'd0, 32'h77, 32'h66, 32'd0, 4'd6);
        tick();
        chk("pre_reset_issue", {31'd0, rdy_alu_out}, 32'd1);
        #2 rst_in = 1'b1;
        #1;
        chk("mid_reset_rdy_alu", {31'd0, rdy_alu_out}, 32'd0);
        chk("mid_reset_full", {31'd0, rs_full_out}, 32'd0);
        chk("mid_reset_vj_out", vj_alu_out, 32'd0);
        tick();
        rst_in = 1'b0;
        cdb(1'b1, 4'd9, 32'h99, 1'b0, 4'd0, 32'd0);
        tick();
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        tick(); tick(); tick();

        // Fill all 16 slots waiting on tag 2
        for (int i = 0; i < 16; i++) begin
            push(6'(i + 2), 32'd9, 32'(i), 32'(i * 3), 32'h100 + 32'(i * 4), 4'((i % 15) + 1));
            disp(6'(i + 2), 32'h100 + 32'(i * 4), 4'd2, 4'd0, 32'd0, 32'(i), 32'(i * 3),
                 4'((i % 15) + 1));
            if (i == 14) chk("not_full_at_15", {31'd0, rs_full_out}, 32'd0);
        end
        chk("full_at_16", {31'd0, rs_full_out}, 32'd1);
        disp(6'h3F, 32'hDEAD, 4'd0, 4'd0, 32'h1, 32'h1, 32'h1, 4'd15);
        chk("full_after_17th", {31'd0, rs_full_out}, 32'd1);
        cdb(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'd9);
        tick();
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("burst_issue_%0d", k), {31'd0, rdy_alu_out}, 32'd1);
            if (k == 0) chk("full_drops", {31'd0, rs_full_out}, 32'd0);
        end
        tick();
        chk("burst_end", {31'd0, rdy_alu_out}, 32'd0);

        // Stall: issue pulse drops and the waiting op holds for 3 cycles
        push(6'h21, 32'h1, 32'h2, 32'h3, 32'h3000, 4'd1);
        push(6'h22, 32'h4, 32'h5, 32'h6, 32'h3004, 4'd2);
        disp(6'h21, 32'h3000, 4'd0, 4'd0, 32'h1, 32'h2, 32'h3, 4'd1);
        disp(6'h22, 32'h3004, 4'd0, 4'd0, 32'h4, 32'h5, 32'h6, 4'd2);
        chk("pre_stall_issue", {31'd0, rdy_alu_out}, 32'd1);
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall_no_issue_%0d", k), {31'd0, rdy_alu_out}, 32'd0);
        end
        chk("stall_hold_rob", {28'd0, rob_id_alu_out}, 32'd1);
        rdy_in = 1'b1;
        tick();
        chk("post_stall_issue", {31'd0, rdy_alu_out}, 32'd1);
        tick();

        // Clear with 4 waiting entries; the same-cycle dispatch is dropped
        for (int i = 0; i < 4; i++) begin
            disp(6'h30, 32'h4000 + 32'(i), 4'd8, 4'd0, 32'd0, 32'd0, 32'd0, 4'(i + 3));
        end
        clear_in = 1'b1;
        set_disp(6'h31, 32'h4100, 4'd0, 4'd0, 32'h5, 32'h5, 32'h5, 4'd12);
        tick();
        clear_in = 1'b0;
        rdy_disp_in = 1'b0;
        chk("clear_no_issue", {31'd0, rdy_alu_out}, 32'd0);
        cdb(1'b1, 4'd8, 32'h88, 1'b0, 4'd0, 32'd0);
        tick();
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("clear_empty_%0d", k), {31'd0, rdy_alu_out}, 32'd0);
        end

        tick(); tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
